// File: rtl/pc_fetch_seq_pkg.sv
// pc_fetch_seq_pkg: shared state encoding, default vectors and alignment helper
package pc_fetch_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [1:0]  ALIGN_OK     = 2'b00;
    function automatic logic aligned(input logic [31:0] a);
        return a[1:0] == ALIGN_OK;
    endfunction
endpackage

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: fetch-stage sequencer owning the PC and the imem request handshake
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic [31:0] instr_f,
    output logic        instr_valid_f,
    output logic        adel_f
);
    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        drop, drop_nxt;

    // register all sequencer state; reset takes effect without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            instr_q  <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_nxt;
            instr_q  <= instr_nxt;
            drop     <= drop_nxt;
        end
    end

    // next-state logic; exc_req overrides everything, a pending request is drained via drop
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = req_addr;
        instr_nxt = instr_q;
        drop_nxt  = drop;
        if (exc_req) begin
            pc_nxt = EXC_PC;
            if (state == REQ) begin
                req_nxt  = imem_ack ? EXC_PC : req_addr;
                drop_nxt = !imem_ack;
            end else begin
                req_nxt   = EXC_PC;
                state_nxt = REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (aligned(pc)) begin
                        req_nxt   = pc;
                        state_nxt = REQ;
                    end else begin
                        instr_nxt = '0;
                        state_nxt = HOLD;
                    end
                end
                REQ: begin
                    if (imem_ack && drop) begin
                        drop_nxt = 1'b0;
                        req_nxt  = pc;
                    end else if (imem_ack) begin
                        instr_nxt = imem_rdata;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_nxt = npc_in;
                        if (aligned(npc_in)) begin
                            req_nxt   = npc_in;
                            state_nxt = REQ;
                        end else begin
                            instr_nxt = '0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign imem_req      = state == REQ;
    assign imem_addr     = req_addr;
    assign pc_f          = pc;
    assign pc4_f         = pc + 32'd4;
    assign instr_f       = instr_q;
    assign instr_valid_f = state == HOLD;
    assign adel_f        = instr_valid_f && !aligned(pc);
endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Fetch-stage sequencer that owns the PC register and drives a multi-cycle instruction-memory handshake.
- Issues a fetch at the current PC, then holds the returned instruction in F until decode accepts it.
- On acceptance, loads the next PC from the combinational next-PC unit (npc_in), or the exception vector on exc_req.
- Sits between the next-PC unit and the F/D pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_PC, 32'h0000_4180, PC loaded on exception request

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
npc_in  input  32  next PC from the next-PC unit, valid in the accept cycle
stall  input  1  decode cannot accept this cycle
exc_req  input  1  redirect to EXC_PC (single-cycle pulse)
imem_req  output  1  fetch request, held until ack
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  instruction valid on imem_rdata this cycle
imem_rdata  input  32  fetched instruction
pc_f  output  32  PC of the instruction held in F
pc4_f  output  32  pc_f + 4
instr_f  output  32  instruction held in F
instr_valid_f  output  1  instr_f/pc_f valid for decode
adel_f  output  1  held PC is misaligned (pc_f[1:0]!=0); qualified by instr_valid_f

Behaviour:
- Reset: the block must take the reset values immediately on reset assertion, not at the next clock edge.
  - Reset values: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, drop=0.
  - Outputs: imem_req=0, instr_f=0, instr_valid_f=0, adel_f=0, pc_f=RESET_PC.
- States: IDLE, REQ, HOLD.
- IDLE: exactly one cycle after reset release.
  - If pc aligned: req_addr<=pc, go REQ.
  - Else: go HOLD with instr_f=0, adel_f=1.
- REQ:
  - imem_req=1, imem_addr=req_addr.
  - req_addr never changes while in REQ.
  - imem_ack && !drop: instr_f<=imem_rdata, instr_valid_f<=1, go HOLD.
  - imem_ack && drop: data discarded, drop<=0, req_addr<=pc, stay REQ. A new request is issued the next cycle.
- HOLD:
  - instr_valid_f=1; outputs stable while stall=1.
  - Accept condition: stall=0. On accept: pc<=npc_in, instr_valid_f<=0.
  - After accept: go REQ with req_addr<=npc_in. If npc_in[1:0]!=0, no memory request; go HOLD next cycle with instr_f=0, adel_f=1.
- Latency: fetch issued the cycle after accept. Minimum 2 cycles per instruction when imem_ack arrives in the first REQ cycle.
- exc_req has the highest priority in every state:
  - pc<=EXC_PC, instr_valid_f<=0, adel_f<=0.
  - In REQ without ack this cycle: drop<=1. The outstanding request runs to its ack and is discarded; then EXC_PC is fetched.
  - In REQ with ack this cycle: data discarded, req_addr<=EXC_PC, stay REQ.
  - In HOLD or IDLE: req_addr<=EXC_PC, go REQ.
  - exc_req together with an accept: the exception wins; npc_in is ignored.
- pc_f always equals the pc register; pc4_f = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- exc_req while drop is already 1: pc is reloaded with EXC_PC and drop stays 1. Only one discard per outstanding request.
- stall has no effect outside HOLD.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, REQ, HOLD);
  - RESET_PC and EXC_PC defaults;
  - the misalignment check constant (2'b00).
- No sub-module; a single always block for state and registers plus combinational output assigns.

Test Plan:
- Reset, ack fixed one cycle after req -> imem_addr 0x3000, then 0x3004 after accept with npc_in=0x3004; instr_valid_f pulses, pc_f tracks.
- HOLD with stall=1 for 3 cycles, imem_rdata changing -> instr_f and pc_f unchanged; no imem_req until stall=0.
- Accept with npc_in=0x0000_3402 -> no imem_req; HOLD next cycle with instr_f=0, adel_f=1, pc_f=0x3402.
- exc_req during REQ with ack delayed 4 cycles -> imem_addr stays the old address until ack; data discarded; next request at 0x4180; instr_valid_f only for the 0x4180 fetch.
- exc_req in the same cycle as an accept (npc_in=0x3100) -> next request at 0x4180, never 0x3100.
- Reset asserted mid-REQ without a clock edge -> outputs take reset values immediately; after release, IDLE then request at 0x3000.
